// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: radix-2 shift-add multiplier and restoring divider
// that stalls EX while running and presents the {hiwen,lowen,hidata,lodata} bundle when done.
module muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic                op_div,
    input  logic                op_divu,
    input  logic                op_mult,
    input  logic                op_multu,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    input  logic                ex_stall,
    input  logic                cancel,
    output logic                stallreq,
    output logic                busy,
    output logic                result_valid,
    output logic [2*XLEN+1:0]   hilo_bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_is_div;
    logic                r_is_signed;
    logic                r_sign_q;
    logic                r_sign_r;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic                w_last;
    logic [XLEN-1:0]     w_a_abs;
    logic [XLEN-1:0]     w_b_abs;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_sh;
    logic                w_rem_ge;
    logic [XLEN-1:0]     w_rem_sub;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_hi;
    logic [XLEN-1:0]     w_lo;

    assign w_accept = op_valid & ~cancel & (op_div | op_divu | op_mult | op_multu);
    assign w_last   = (r_cnt == CNT_W'(XLEN - 1));
    assign busy     = (r_state != S_IDLE);

    // Magnitudes are only meaningful for signed ops; unsigned operands pass through.
    assign w_a_abs = (r_is_signed & r_a[XLEN-1]) ? -r_a : r_a;
    assign w_b_abs = (r_is_signed & r_b[XLEN-1]) ? -r_b : r_b;

    // Shift-add: acc = {partial_hi, multiplier}; the carry out re-enters at the top on the shift.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide: acc = {rem, quo}; the shifted remainder needs one extra bit for the compare.
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_b;
    assign w_div_next = {(w_rem_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_rem_ge};

    always_comb begin
        w_state_next = r_state;
        stallreq     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_PREP;
                    stallreq     = 1'b1;
                end
            end
            S_PREP: begin
                stallreq     = 1'b1;
                w_state_next = S_ITER;
            end
            S_ITER: begin
                stallreq = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!ex_stall) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (cancel) begin
            w_state_next = S_IDLE;
            stallreq     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div    <= op_div | op_divu;
                        r_is_signed <= op_div | op_mult;
                        r_a         <= op_a;
                        r_b         <= op_b;
                    end
                end
                S_PREP: begin
                    r_sign_q <= r_is_signed & (r_a[XLEN-1] ^ r_b[XLEN-1]);
                    r_sign_r <= r_is_signed & r_a[XLEN-1];
                    r_cnt    <= '0;
                    if (r_is_div) begin
                        r_b   <= w_b_abs;
                        r_acc <= {{XLEN{1'b0}}, w_a_abs};
                    end else begin
                        r_a   <= w_a_abs;
                        r_acc <= {{XLEN{1'b0}}, w_b_abs};
                    end
                end
                S_ITER: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Signs are reapplied here only; r_acc is stable for as long as DONE is held.
    assign w_prod = r_sign_q ? -r_acc : r_acc;

    always_comb begin
        if (r_is_div) begin
            w_hi = r_sign_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
            w_lo = r_sign_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        end else begin
            w_hi = w_prod[2*XLEN-1:XLEN];
            w_lo = w_prod[XLEN-1:0];
        end
    end

    assign result_valid = (r_state == S_DONE) & ~cancel;
    assign hilo_bus     = result_valid ? {2'b11, w_hi, w_lo} : {(2*XLEN+2){1'b0}};

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

    localparam int XLEN = 32;
    localparam int K_DIV = 0, K_DIVU = 1, K_MULT = 2, K_MULTU = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               op_valid, op_div, op_divu, op_mult, op_multu;
    logic [XLEN-1:0]    op_a, op_b;
    logic               ex_stall, cancel;
    logic               stallreq, busy, result_valid;
    logic [2*XLEN+1:0]  hilo_bus;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_div(op_div), .op_divu(op_divu),
        .op_mult(op_mult), .op_multu(op_multu),
        .op_a(op_a), .op_b(op_b),
        .ex_stall(ex_stall), .cancel(cancel),
        .stallreq(stallreq), .busy(busy), .result_valid(result_valid),
        .hilo_bus(hilo_bus)
    );

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} straight from the arithmetic definition of each instruction.
    function automatic logic [63:0] model(input int kind, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (kind)
            K_MULT: begin
                p = sa * sb;
                return p[63:0];
            end
            K_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                return up;
            end
            K_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic drive_op(input int kind, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op_div   = (kind == K_DIV);
        op_divu  = (kind == K_DIVU);
        op_mult  = (kind == K_MULT);
        op_multu = (kind == K_MULTU);
        op_a     = a;
        op_b     = b;
    endtask

    task automatic clear_op();
        op_valid = 1'b0;
        op_div   = 1'b0;
        op_divu  = 1'b0;
        op_mult  = 1'b0;
        op_multu = 1'b0;
        op_a     = '0;
        op_b     = '0;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] b, input int nstall);
        logic [63:0] exp;
        int n;
        exp = model(kind, a, b);
        step();
        drive_op(kind, a, b);
        #1;
        n = 0;
        while (stallreq && n < 100) begin
            n++;
            step();
            clear_op();
            #1;
        end
        check("stall_len", 66'(n), 66'd34);
        check("result_valid", 66'(result_valid), 66'd1);
        check("bundle", 66'(hilo_bus), {2'b11, exp});
        $display("op kind=%0d a=%h b=%h -> hi=%h lo=%h (expect %h) stall=%0d",
                 kind, a, b, hilo_bus[63:32], hilo_bus[31:0], exp, n);
        for (int i = 0; i < nstall; i++) begin
            ex_stall = 1'b1;
            step();
            #1;
            check("held_bundle", 66'(hilo_bus), {2'b11, exp});
        end
        ex_stall = 1'b0;
        step();
        #1;
        check("post_rv", 66'(result_valid), 66'd0);
        check("post_bus", 66'(hilo_bus), 66'd0);
        check("post_busy", 66'(busy), 66'd0);
    endtask

    // Cancel at cycle index 'at' counted from the accept cycle (index 2 is ITER cnt=0).
    task automatic do_cancel(input int kind, input logic [31:0] a, input logic [31:0] b, input int at);
        step();
        drive_op(kind, a, b);
        #1;
        for (int i = 0; i < at; i++) begin
            step();
            clear_op();
            #1;
        end
        if (at < 34) check("pre_cancel_stall", 66'(stallreq), 66'd1);
        cancel = 1'b1;
        #1;
        check("cancel_stall", 66'(stallreq), 66'd0);
        check("cancel_rv", 66'(result_valid), 66'd0);
        check("cancel_bus", 66'(hilo_bus), 66'd0);
        step();
        cancel = 1'b0;
        clear_op();
        #1;
        check("cancel_idle", 66'(busy), 66'd0);
        $display("cancel kind=%0d at=%0d busy=%0b stallreq=%0b", kind, at, busy, stallreq);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst      = 1'b1;
        ex_stall = 1'b0;
        cancel   = 1'b0;
        clear_op();
        repeat (3) @(posedge clk);
        #1;
        check("rst_stallreq", 66'(stallreq), 66'd0);
        check("rst_busy", 66'(busy), 66'd0);
        check("rst_rv", 66'(result_valid), 66'd0);
        check("rst_bus", 66'(hilo_bus), 66'd0);
        rst = 1'b0;

        do_op(K_DIVU, 32'd100, 32'd7, 0);
        do_op(K_DIV, -32'd7, 32'd2, 0);
        do_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(K_MULT, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(K_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(K_DIVU, 32'd5, 32'd0, 0);
        do_op(K_DIV, -32'd5, 32'd0, 0);
        do_cancel(K_DIVU, 32'd100, 32'd7, 12);
        do_op(K_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 3);
        do_op(K_DIVU, 32'hDEAD_BEEF, 32'd13, 0);
        do_cancel(K_MULT, 32'd3, 32'd4, 0);
        do_cancel(K_DIV, 32'd9, 32'd2, 34);

        // Reset in the middle of an operation discards everything.
        step();
        drive_op(K_MULT, 32'd6, 32'd7);
        for (int i = 0; i < 5; i++) begin
            step();
            clear_op();
        end
        rst = 1'b1;
        step();
        #1;
        check("midrst_busy", 66'(busy), 66'd0);
        check("midrst_stall", 66'(stallreq), 66'd0);
        rst = 1'b0;
        do_op(K_MULT, -32'd6, 32'd7, 1);

        for (int t = 0; t < 60; t++) begin
            int k;
            logic [31:0] a, b;
            k = int'($urandom_range(0, 3));
            a = pick();
            b = pick();
            if ($urandom_range(0, 9) == 0) begin
                do_cancel(k, a, b, int'($urandom_range(1, 34)));
            end else begin
                do_op(k, a, b, int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
